// File: rtl/mmio_router_pkg.sv
// Shared types and constants for the AXI-lite MMIO router and its slot decoder.
package mmio_router_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  localparam logic [15:0] BASE_HI_DEFAULT = 16'h4600;

  // Slot index lives in addr[15:8]; the register offset in addr[7:0].
  localparam int SLOT_LSB = 8;
  localparam int SLOT_MSB = 15;
  localparam int SLOT_W   = SLOT_MSB - SLOT_LSB + 1;

endpackage

// File: rtl/mmio_slot_decoder.sv
// Combinational address/protection decode of an AXI-lite access into an MMIO slot.
module mmio_slot_decoder
  import mmio_router_pkg::*;
#(
  parameter int          NUM_SLOTS   = 4,
  parameter logic [15:0] BASE_HI     = BASE_HI_DEFAULT,
  parameter bit          SECURE_ONLY = 1'b1
) (
  input  logic [31:0]       addr,
  input  logic [2:0]        prot,
  output logic [SLOT_W-1:0] slot,
  output logic              dec_err,
  output logic              sec_err
);

  logic unused_bits;
  assign unused_bits = ^{addr[SLOT_LSB-1:0], prot[2], prot[0]};

  assign slot    = addr[SLOT_MSB:SLOT_LSB];
  // Extra bit so NUM_SLOTS=256 compares correctly against an 8-bit slot.
  assign dec_err = (addr[31:16] != BASE_HI) || ({1'b0, slot} >= 9'(NUM_SLOTS));
  assign sec_err = SECURE_ONLY && prot[1];

endmodule

// File: rtl/axi_lite_mmio_router.sv
// AXI-lite slave routing single outstanding accesses to NUM_SLOTS MMIO devices
// over a per-slot req/ack bus, with decode, security and timeout errors.
module axi_lite_mmio_router
  import mmio_router_pkg::*;
#(
  parameter int          NUM_SLOTS   = 4,
  parameter logic [15:0] BASE_HI     = BASE_HI_DEFAULT,
  parameter int          TIMEOUT     = 255,
  parameter bit          SECURE_ONLY = 1'b1
) (
  input  logic                    aclk,
  input  logic                    rst,
  input  logic [31:0]             S_AXI_awaddr,
  input  logic [2:0]              S_AXI_awprot,
  input  logic                    S_AXI_awvalid,
  output logic                    S_AXI_awready,
  input  logic [31:0]             S_AXI_wdata,
  input  logic [3:0]              S_AXI_wstrb,
  input  logic                    S_AXI_wvalid,
  output logic                    S_AXI_wready,
  output logic [1:0]              S_AXI_bresp,
  output logic                    S_AXI_bvalid,
  input  logic                    S_AXI_bready,
  input  logic [31:0]             S_AXI_araddr,
  input  logic [2:0]              S_AXI_arprot,
  input  logic                    S_AXI_arvalid,
  output logic                    S_AXI_arready,
  output logic [31:0]             S_AXI_rdata,
  output logic [1:0]              S_AXI_rresp,
  output logic                    S_AXI_rvalid,
  input  logic                    S_AXI_rready,
  output logic [NUM_SLOTS-1:0]    dev_req,
  output logic                    dev_we,
  output logic [7:0]              dev_addr,
  output logic [31:0]             dev_wdata,
  output logic [3:0]              dev_wstrb,
  input  logic [NUM_SLOTS-1:0]    dev_ack,
  input  logic [NUM_SLOTS*32-1:0] dev_rdata,
  input  logic [NUM_SLOTS-1:0]    dev_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e            state, state_n;
  logic              aw_held, aw_held_n, w_held, w_held_n, ar_held, ar_held_n;
  logic              awready_q, wready_q, arready_q;
  logic              prio, prio_n;            // 0: write wins a tie, 1: read wins
  logic              cur_we, cur_we_n;
  logic [SLOT_W-1:0] cur_slot, cur_slot_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [1:0]        bresp_q, bresp_n, rresp_q, rresp_n;
  logic [31:0]       rdata_q, rdata_n;

  logic [31:0]       awaddr_q, araddr_q, wdata_q;
  logic [2:0]        awprot_q, arprot_q;
  logic [3:0]        wstrb_q;

  logic              aw_hs, w_hs, ar_hs;
  logic              wr_pend, any_pend, contested, grant_we;
  logic [31:0]       g_addr;
  logic [2:0]        g_prot;
  logic [SLOT_W-1:0] g_slot;
  logic              g_dec_err, g_sec_err;
  logic              ack_sel, err_sel;
  logic [31:0]       rdata_sel;

  assign aw_hs = S_AXI_awvalid && awready_q;
  assign w_hs  = S_AXI_wvalid && wready_q;
  assign ar_hs = S_AXI_arvalid && arready_q;

  assign wr_pend   = aw_held && w_held;
  assign any_pend  = wr_pend || ar_held;
  assign contested = wr_pend && ar_held;
  assign grant_we  = contested ? !prio : wr_pend;
  assign g_addr    = grant_we ? awaddr_q : araddr_q;
  assign g_prot    = grant_we ? awprot_q : arprot_q;

  mmio_slot_decoder #(
    .NUM_SLOTS   (NUM_SLOTS),
    .BASE_HI     (BASE_HI),
    .SECURE_ONLY (SECURE_ONLY)
  ) u_dec (
    .addr    (g_addr),
    .prot    (g_prot),
    .slot    (g_slot),
    .dec_err (g_dec_err),
    .sec_err (g_sec_err)
  );

  always_comb begin
    ack_sel   = 1'b0;
    err_sel   = 1'b0;
    rdata_sel = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (cur_slot == SLOT_W'(k)) begin
        ack_sel   = dev_ack[k];
        err_sel   = dev_err[k];
        rdata_sel = dev_rdata[k*32 +: 32];
      end
    end
  end

  always_comb begin
    state_n    = state;
    aw_held_n  = aw_held || aw_hs;
    w_held_n   = w_held || w_hs;
    ar_held_n  = ar_held || ar_hs;
    prio_n     = prio;
    cur_we_n   = cur_we;
    cur_slot_n = cur_slot;
    cnt_n      = cnt;
    bresp_n    = bresp_q;
    rresp_n    = rresp_q;
    rdata_n    = rdata_q;
    case (state)
      IDLE: begin
        if (any_pend) begin
          cur_we_n   = grant_we;
          cur_slot_n = g_slot;
          cnt_n      = '0;
          if (contested) prio_n = !prio;
          if (g_dec_err || g_sec_err) begin
            state_n = RESP;
            if (grant_we) bresp_n = g_dec_err ? RESP_DECERR : RESP_SLVERR;
            else begin
              rresp_n = g_dec_err ? RESP_DECERR : RESP_SLVERR;
              rdata_n = '0;
            end
          end else begin
            state_n = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (ack_sel || (cnt == CNT_W'(TIMEOUT - 1))) begin
          state_n = RESP;
          // A timeout reports like a device error; ack wins when both coincide.
          if (cur_we) bresp_n = (ack_sel && !err_sel) ? RESP_OKAY : RESP_SLVERR;
          else begin
            rresp_n = (ack_sel && !err_sel) ? RESP_OKAY : RESP_SLVERR;
            rdata_n = (ack_sel && !err_sel) ? rdata_sel : '0;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RESP: begin
        if (cur_we && S_AXI_bready) begin
          aw_held_n = 1'b0;
          w_held_n  = 1'b0;
          state_n   = IDLE;
        end else if (!cur_we && S_AXI_rready) begin
          ar_held_n = 1'b0;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      state     <= IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      ar_held   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      prio      <= 1'b0;
      cur_we    <= 1'b0;
      cur_slot  <= '0;
      cnt       <= '0;
      bresp_q   <= 2'b00;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
    end else begin
      state     <= state_n;
      aw_held   <= aw_held_n;
      w_held    <= w_held_n;
      ar_held   <= ar_held_n;
      awready_q <= !aw_held_n && (state_n == IDLE);
      wready_q  <= !w_held_n && (state_n == IDLE);
      arready_q <= !ar_held_n && (state_n == IDLE);
      prio      <= prio_n;
      cur_we    <= cur_we_n;
      cur_slot  <= cur_slot_n;
      cnt       <= cnt_n;
      bresp_q   <= bresp_n;
      rresp_q   <= rresp_n;
      rdata_q   <= rdata_n;
    end
  end

  always_ff @(posedge aclk) begin
    if (aw_hs) begin
      awaddr_q <= S_AXI_awaddr;
      awprot_q <= S_AXI_awprot;
    end
    if (w_hs) begin
      wdata_q <= S_AXI_wdata;
      wstrb_q <= S_AXI_wstrb;
    end
    if (ar_hs) begin
      araddr_q <= S_AXI_araddr;
      arprot_q <= S_AXI_arprot;
    end
  end

  always_comb begin
    dev_req = '0;
    if (state == ACCESS) begin
      for (int k = 0; k < NUM_SLOTS; k++) dev_req[k] = (cur_slot == SLOT_W'(k));
    end
  end

  assign dev_we        = cur_we;
  assign dev_addr      = cur_we ? awaddr_q[7:0] : araddr_q[7:0];
  assign dev_wdata     = wdata_q;
  assign dev_wstrb     = wstrb_q;
  assign S_AXI_awready = awready_q;
  assign S_AXI_wready  = wready_q;
  assign S_AXI_arready = arready_q;
  assign S_AXI_bvalid  = (state == RESP) && cur_we;
  assign S_AXI_rvalid  = (state == RESP) && !cur_we;
  assign S_AXI_bresp   = bresp_q;
  assign S_AXI_rresp   = rresp_q;
  assign S_AXI_rdata   = rdata_q;

endmodule

// File: tb/tb_axi_lite_mmio_router.sv
// Directed bench for axi_lite_mmio_router: 4 slots, TIMEOUT=8, secure-only.
module tb_axi_lite_mmio_router;

  logic         aclk = 1'b0;
  logic         rst;
  logic [31:0]  awaddr, wdata, araddr, rdata;
  logic [2:0]   awprot, arprot;
  logic [3:0]   wstrb;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [1:0]   bresp, rresp;
  logic [3:0]   dev_req, dev_ack, dev_err, dev_wstrb;
  logic         dev_we;
  logic [7:0]   dev_addr;
  logic [31:0]  dev_wdata;
  logic [127:0] dev_rdata;

  int n_tests = 0;
  int n_fail = 0;
  int onehot_viol = 0;

  always #5 aclk = ~aclk;

  axi_lite_mmio_router #(
    .NUM_SLOTS   (4),
    .BASE_HI     (16'h4600),
    .TIMEOUT     (8),
    .SECURE_ONLY (1'b1)
  ) dut (
    .aclk          (aclk),
    .rst           (rst),
    .S_AXI_awaddr  (awaddr),
    .S_AXI_awprot  (awprot),
    .S_AXI_awvalid (awvalid),
    .S_AXI_awready (awready),
    .S_AXI_wdata   (wdata),
    .S_AXI_wstrb   (wstrb),
    .S_AXI_wvalid  (wvalid),
    .S_AXI_wready  (wready),
    .S_AXI_bresp   (bresp),
    .S_AXI_bvalid  (bvalid),
    .S_AXI_bready  (bready),
    .S_AXI_araddr  (araddr),
    .S_AXI_arprot  (arprot),
    .S_AXI_arvalid (arvalid),
    .S_AXI_arready (arready),
    .S_AXI_rdata   (rdata),
    .S_AXI_rresp   (rresp),
    .S_AXI_rvalid  (rvalid),
    .S_AXI_rready  (rready),
    .dev_req       (dev_req),
    .dev_we        (dev_we),
    .dev_addr      (dev_addr),
    .dev_wdata     (dev_wdata),
    .dev_wstrb     (dev_wstrb),
    .dev_ack       (dev_ack),
    .dev_rdata     (dev_rdata),
    .dev_err       (dev_err)
  );

  always @(negedge aclk) begin
    if ($countones(dev_req) > 1) onehot_viol++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue_ar(input logic [31:0] a, input logic [2:0] p);
    araddr  = a;
    arprot  = p;
    arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
  endtask

  task automatic issue_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [2:0] p);
    awaddr  = a;
    awprot  = p;
    wdata   = d;
    wstrb   = s;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    tick();
    awvalid = 1'b0;
    wvalid  = 1'b0;
  endtask

  task automatic ack(input int k, input logic e, input logic [31:0] d);
    dev_ack            = '0;
    dev_ack[k]         = 1'b1;
    dev_err[k]         = e;
    dev_rdata[k*32+:32] = d;
    tick();
    dev_ack = '0;
    dev_err = '0;
  endtask

  initial begin
    rst = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
    dev_ack = '0; dev_err = '0; dev_rdata = '0;
    tick();
    tick();
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_dev_req", 32'(dev_req), 32'd0);
    chk("rst_bresp", 32'(bresp), 32'd0);
    chk("rst_rresp", 32'(rresp), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_awready", 32'(awready), 32'd1);
    chk("idle_arready", 32'(arready), 32'd1);

    // Write slot 1 with AW and W together, ack on first ACCESS cycle
    issue_wr(32'h4600_0104, 32'hDEAD_BEEF, 4'hF, 3'b000);
    chk("t1_awready_low", 32'(awready), 32'd0);
    chk("t1_wready_low", 32'(wready), 32'd0);
    chk("t1_req_pre", 32'(dev_req), 32'd0);
    tick();
    chk("t1_req", 32'(dev_req), 32'b0010);
    chk("t1_we", 32'(dev_we), 32'd1);
    chk("t1_addr", 32'(dev_addr), 32'h04);
    chk("t1_wdata", dev_wdata, 32'hDEAD_BEEF);
    chk("t1_wstrb", 32'(dev_wstrb), 32'hF);
    ack(1, 1'b0, 32'h0);
    chk("t1_bvalid", 32'(bvalid), 32'd1);
    chk("t1_bresp", 32'(bresp), 32'd0);
    chk("t1_req_done", 32'(dev_req), 32'd0);
    tick();
    chk("t1_bvalid_clr", 32'(bvalid), 32'd0);
    chk("t1_awready_back", 32'(awready), 32'd1);

    // W two cycles ahead of AW; device error; bready held low
    bready = 1'b0;
    wdata = 32'h1234_5678; wstrb = 4'h3; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("t2_wready_low", 32'(wready), 32'd0);
    tick();
    chk("t2_req_noaw", 32'(dev_req), 32'd0);
    tick();
    chk("t2_req_noaw2", 32'(dev_req), 32'd0);
    chk("t2_awready", 32'(awready), 32'd1);
    awaddr = 32'h4600_0008; awprot = 3'b000; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("t2_req_pre", 32'(dev_req), 32'd0);
    tick();
    chk("t2_req", 32'(dev_req), 32'b0001);
    chk("t2_addr", 32'(dev_addr), 32'h08);
    chk("t2_wdata", dev_wdata, 32'h1234_5678);
    chk("t2_wstrb", 32'(dev_wstrb), 32'h3);
    ack(0, 1'b1, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("t2_bvalid_hold", 32'(bvalid), 32'd1);
      chk("t2_bresp_hold", 32'(bresp), 32'd2);
      tick();
    end
    bready = 1'b1;
    tick();
    chk("t2_bvalid_clr", 32'(bvalid), 32'd0);

    // Successful read, then two decode errors
    issue_ar(32'h4600_0310, 3'b000);
    tick();
    chk("t3_req", 32'(dev_req), 32'b1000);
    chk("t3_we", 32'(dev_we), 32'd0);
    chk("t3_addr", 32'(dev_addr), 32'h10);
    ack(3, 1'b0, 32'hCAFE_F00D);
    chk("t3_rvalid", 32'(rvalid), 32'd1);
    chk("t3_rresp", 32'(rresp), 32'd0);
    chk("t3_rdata", rdata, 32'hCAFE_F00D);
    tick();
    chk("t3_rvalid_clr", 32'(rvalid), 32'd0);
    issue_ar(32'h4600_0710, 3'b000);
    tick();
    chk("t3b_req", 32'(dev_req), 32'd0);
    chk("t3b_rvalid", 32'(rvalid), 32'd1);
    chk("t3b_rresp", 32'(rresp), 32'd3);
    chk("t3b_rdata", rdata, 32'd0);
    tick();
    issue_ar(32'h4700_0100, 3'b000);
    tick();
    chk("t3c_req", 32'(dev_req), 32'd0);
    chk("t3c_rvalid", 32'(rvalid), 32'd1);
    chk("t3c_rresp", 32'(rresp), 32'd3);
    tick();

    // Timeout on slot 2 with a stray ack on slot 0, then device error on slot 1
    issue_ar(32'h4600_0200, 3'b000);
    tick();
    chk("t4_req", 32'(dev_req), 32'b0100);
    dev_ack = 4'b0001;
    tick();
    dev_ack = '0;
    for (int i = 0; i < 6; i++) tick();
    chk("t4_req_still", 32'(dev_req), 32'b0100);
    chk("t4_rvalid_pre", 32'(rvalid), 32'd0);
    tick();
    chk("t4_rvalid", 32'(rvalid), 32'd1);
    chk("t4_rresp", 32'(rresp), 32'd2);
    chk("t4_rdata", rdata, 32'd0);
    chk("t4_req_off", 32'(dev_req), 32'd0);
    tick();
    issue_ar(32'h4600_0120, 3'b000);
    tick();
    chk("t4b_req", 32'(dev_req), 32'b0010);
    ack(1, 1'b1, 32'h55);
    chk("t4b_rvalid", 32'(rvalid), 32'd1);
    chk("t4b_rresp", 32'(rresp), 32'd2);
    chk("t4b_rdata", rdata, 32'd0);
    tick();

    // Contested write/read twice: write first, then read first
    for (int r = 0; r < 2; r++) begin
      awaddr = 32'h4600_0220; awprot = 3'b000; wdata = 32'hA5A5_A5A5; wstrb = 4'hF;
      araddr = 32'h4600_0330; arprot = 3'b000;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      tick();
      if (r == 0) begin
        chk("t5a_first_we", 32'(dev_we), 32'd1);
        chk("t5a_first_req", 32'(dev_req), 32'b0100);
        ack(2, 1'b0, 32'h0);
        chk("t5a_bvalid", 32'(bvalid), 32'd1);
        chk("t5a_rvalid_wait", 32'(rvalid), 32'd0);
        tick();
        tick();
        chk("t5a_second_we", 32'(dev_we), 32'd0);
        chk("t5a_second_req", 32'(dev_req), 32'b1000);
        ack(3, 1'b0, 32'h1122_3344);
        chk("t5a_rdata", rdata, 32'h1122_3344);
        tick();
      end else begin
        chk("t5b_first_we", 32'(dev_we), 32'd0);
        chk("t5b_first_req", 32'(dev_req), 32'b1000);
        ack(3, 1'b0, 32'h0000_0066);
        chk("t5b_rvalid", 32'(rvalid), 32'd1);
        chk("t5b_rdata", rdata, 32'h66);
        tick();
        tick();
        chk("t5b_second_we", 32'(dev_we), 32'd1);
        chk("t5b_second_req", 32'(dev_req), 32'b0100);
        ack(2, 1'b0, 32'h0);
        chk("t5b_bvalid", 32'(bvalid), 32'd1);
        tick();
      end
    end

    // Non-secure write is refused without touching the device
    issue_wr(32'h4600_0104, 32'h1, 4'hF, 3'b010);
    tick();
    chk("t6_req", 32'(dev_req), 32'd0);
    chk("t6_bvalid", 32'(bvalid), 32'd1);
    chk("t6_bresp", 32'(bresp), 32'd2);
    tick();

    // Reset in the middle of an access
    issue_ar(32'h4600_0000, 3'b000);
    tick();
    chk("t7_req_access", 32'(dev_req), 32'b0001);
    rst = 1'b1;
    tick();
    chk("t7_req_rst", 32'(dev_req), 32'd0);
    chk("t7_bvalid_rst", 32'(bvalid), 32'd0);
    chk("t7_rvalid_rst", 32'(rvalid), 32'd0);
    chk("t7_awready_rst", 32'(awready), 32'd0);
    rst = 1'b0;
    tick();
    chk("t7_awready", 32'(awready), 32'd1);
    chk("t7_arready", 32'(arready), 32'd1);
    chk("t7_req_idle", 32'(dev_req), 32'd0);

    chk("req_onehot", 32'(onehot_viol), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
